// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: a small in-order instruction queue feeding an
// immediate decoder, gated by a 32-entry load scoreboard and an illegal-opcode
// halt that only a pipeline flush can clear.

// Immediate extraction for the head instruction, standard RISC-V formats.
module decoder (
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm,
    output logic        o_imm_valid
);

    // Select the immediate layout from the opcode; R-type and unknown opcodes carry none
    always_comb begin
        o_imm       = '0;
        o_imm_valid = 1'b0;
        case (i_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                o_imm       = {{20{i_instr[31]}}, i_instr[31:20]};
                o_imm_valid = 1'b1;
            end
            7'b0100011: begin
                o_imm       = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                o_imm_valid = 1'b1;
            end
            7'b1100011: begin
                o_imm       = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                               i_instr[30:25], i_instr[11:8], 1'b0};
                o_imm_valid = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                o_imm       = {i_instr[31:12], 12'b0};
                o_imm_valid = 1'b1;
            end
            7'b1101111: begin
                o_imm       = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                               i_instr[20], i_instr[30:21], 1'b0};
                o_imm_valid = 1'b1;
            end
            default: begin
                o_imm       = '0;
                o_imm_valid = 1'b0;
            end
        endcase
    end

endmodule

module decode_issue_ctrl #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_ready,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_imm,
    output logic            id_imm_valid,
    input  logic            ld_done,
    input  logic [4:0]      ld_rd,
    input  logic            flush,
    output logic            illegal,
    output logic [PC_W-1:0] illegal_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_instr_q [DEPTH];
    logic [PC_W-1:0]   r_pc_q    [DEPTH];
    logic [31:0]       r_busy;
    logic              r_illegal;
    logic [PC_W-1:0]   r_illegal_pc;

    logic [31:0]       w_head_instr;
    logic [PC_W-1:0]   w_head_pc;
    logic [6:0]        w_opcode;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic              w_uses_rs1;
    logic              w_uses_rs2;
    logic              w_writes_rd;
    logic              w_legal;
    logic              w_hazard;
    logic              w_not_empty;
    logic              w_enq;
    logic              w_deq;
    logic              w_illegal_evt;
    logic [31:0]       w_ld_clr;
    logic [31:0]       w_busy_eff;
    logic [31:0]       w_busy_nxt;

    assign w_head_instr = r_instr_q[r_rd_ptr];
    assign w_head_pc    = r_pc_q[r_rd_ptr];
    assign w_opcode     = w_head_instr[6:0];
    assign w_rd         = w_head_instr[11:7];
    assign w_rs1        = w_head_instr[19:15];
    assign w_rs2        = w_head_instr[24:20];
    assign w_not_empty  = (r_count != '0);

    assign id_instr   = w_head_instr;
    assign id_pc      = w_head_pc;
    assign illegal    = r_illegal;
    assign illegal_pc = r_illegal_pc;

    // Registered count gates acceptance, so a full queue refuses fetch even while draining
    assign if_ready = (r_count < FULL) && !flush && !rst;
    assign w_enq    = if_valid && if_ready;
    assign w_deq    = id_valid && id_ready;

    decoder u_decoder (
        .i_instr     (w_head_instr),
        .o_imm       (id_imm),
        .o_imm_valid (id_imm_valid)
    );

    // Classify the head opcode by which register fields it reads and writes
    always_comb begin
        w_uses_rs1  = 1'b0;
        w_uses_rs2  = 1'b0;
        w_writes_rd = 1'b0;
        case (w_opcode)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_uses_rs1  = 1'b1;
                w_writes_rd = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            7'b0110011: begin
                w_uses_rs1  = 1'b1;
                w_uses_rs2  = 1'b1;
                w_writes_rd = 1'b1;
            end
            7'b1101111, 7'b0110111, 7'b0010111: begin
                w_writes_rd = 1'b1;
            end
            default: begin
                w_uses_rs1  = 1'b0;
                w_uses_rs2  = 1'b0;
                w_writes_rd = 1'b0;
            end
        endcase
        w_legal = w_uses_rs1 || w_uses_rs2 || w_writes_rd;
    end

    // Effective busy view lets a returning load release its register in the same cycle
    always_comb begin
        w_ld_clr = '0;
        if (ld_done) begin
            w_ld_clr[ld_rd] = 1'b1;
        end
        w_busy_eff    = r_busy & ~w_ld_clr;
        w_busy_eff[0] = 1'b0;
        w_hazard = (w_uses_rs1  && w_busy_eff[w_rs1]) ||
                   (w_uses_rs2  && w_busy_eff[w_rs2]) ||
                   (w_writes_rd && w_busy_eff[w_rd]);
    end

    // Next scoreboard: clear the returning load first so an issuing load's set wins
    always_comb begin
        w_busy_nxt = w_busy_eff;
        if (w_deq && (w_opcode == OP_LOAD) && (w_rd != 5'd0)) begin
            w_busy_nxt[w_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Issue/halt decision; an illegal head stays queued and parks the FSM until flush
    always_comb begin
        w_state_nxt   = r_state;
        id_valid      = 1'b0;
        w_illegal_evt = 1'b0;
        case (r_state)
            RUN: begin
                if (!flush && w_not_empty) begin
                    if (!w_legal) begin
                        w_illegal_evt = 1'b1;
                        w_state_nxt   = HALT;
                    end else if (!w_hazard) begin
                        id_valid = 1'b1;
                    end
                end
            end
            HALT: begin
                id_valid = 1'b0;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
        if (flush) begin
            w_state_nxt = RUN;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Queue pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage needs no reset; occupancy decides what is meaningful
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_instr_q[r_wr_ptr] <= if_instr;
            r_pc_q[r_wr_ptr]    <= if_pc;
        end
    end

    // Load scoreboard register; flush leaves it alone since loads are still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Illegal pulse and the PC it reports, held until the next illegal event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal    <= 1'b0;
            r_illegal_pc <= '0;
        end else begin
            r_illegal <= w_illegal_evt;
            if (w_illegal_evt) begin
                r_illegal_pc <= w_head_pc;
            end
        end
    end

endmodule
